fp_special_pipe: RTL and testbench
==================================

FP_SPECIAL_PIPE -- requirements
Module: fp_special_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, meaning mantissa field width; the word width is W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter DAZ, default 1, meaning subnormal operands are treated as zero when 1.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning special-event counter width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock), rst input 1 (synchronous active-high reset).
REQ-006 The block SHALL have these data and control ports:
- in_valid input 1: operand/core-result pair valid
- in_ready output 1: block accepts the pair
- func input 1: 0 = sin, 1 = cos
- in_op input W: original IEEE754 operand
- core_res input W: result from the sin/cos datapath
- out_valid output 1: result valid
- out_ready input 1: downstream accepts the result
- out_res output W: final result
- out_special output 1: out_res came from special-case logic
- clr_flags input 1: clear sticky flags and counter
- flag_invalid output 1: sticky; an Inf operand was seen
- flag_nan output 1: sticky; a NaN operand was seen
- flag_daz output 1: sticky; a subnormal operand was flushed
- spec_cnt output CNT_W: count of special results delivered

Function
REQ-007 Classification SHALL be: E = exponent field, M = mantissa field; zero = (E==0, M==0) for either sign; subnormal = (E==0, M!=0); inf = (E all-ones, M==0); nan = (E all-ones, M!=0); normal otherwise.
REQ-008 Result selection SHALL be as follows:
- nan -> QNAN = {0, all-ones, all-ones}, which is 0x7FFFFFFF at default widths.
- inf -> QNAN.
- zero, or subnormal with DAZ=1, under sin -> {in_op sign, all zeros}.
- zero, or subnormal with DAZ=1, under cos -> +1.0 = {0, bias=2^(EXP_W-1)-1, 0}, which is 0x3F800000 at default widths.
- all other cases -> core_res unchanged.
REQ-009 Under DAZ=0, subnormal operands SHALL be classed normal and SHALL pass core_res.
REQ-010 out_special SHALL be 1 exactly when a special-case path of REQ-008 was taken.
REQ-011 The pipeline SHALL have two registered stages: stage S1 captures in_op, core_res, func and the class bits; stage S2 holds the selected out_res and its flags.
- Latency from an in_valid&in_ready edge to out_valid SHALL be 2 cycles with no stall.
- Throughput SHALL be 1 per cycle.
REQ-012 Stage-advance rules SHALL be: S2 loads when (~S2 valid | out_ready); S1 advances when S2 loads; in_ready = ~S1 valid | S2 loads.
- in_ready SHALL have no combinational dependency on in_valid.
REQ-013 While out_valid=1 and out_ready=0, out_res, out_special and out_valid SHALL stay stable; there SHALL be no drop and no duplicate.
REQ-014 Pairs SHALL be delivered in acceptance order.
REQ-015 Flag updates SHALL occur on the output handshake (out_valid & out_ready) for the delivered item:
- flag_invalid is set by an inf operand.
- flag_nan is set by a nan operand.
- flag_daz is set by a flushed subnormal.
- spec_cnt increments by 1 when out_special=1, saturating at 2^CNT_W-1.
REQ-016 clr_flags=1 SHALL zero all flags and spec_cnt at the next edge.
REQ-017 When clr_flags coincides with a setting handshake, the set SHALL win: the flag becomes 1 and spec_cnt becomes 1.
REQ-018 clr_flags SHALL NOT affect pipeline contents.

Reset
REQ-019 While rst=1 at a clk edge, the following SHALL be cleared: S1/S2 valid, out_valid, out_res=0, out_special=0, all flags, and spec_cnt.
- in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-020 Reset asserted mid-operation SHALL discard in-flight items; no out_valid SHALL appear for them after reset.

Verification
REQ-021 The bench SHALL cover sin with in_op=0x80000000 and core_res=0x12345678 -> out_res=0x80000000, out_special=1, 2 cycles later, spec_cnt=1.
REQ-022 The bench SHALL cover cos with in_op=0x00000000 -> out_res=0x3F800000; cos with in_op=0x00000001 (DAZ=1) -> 0x3F800000 and flag_daz=1.
REQ-023 The bench SHALL cover in_op=0xFF800000 -> out_res=0x7FFFFFFF, flag_invalid=1; in_op=0x7FC00001 -> 0x7FFFFFFF, flag_nan=1.
REQ-024 The bench SHALL cover a stream of 8 normal operands (in_op=0x3F000000) with out_ready held 0 for 5 cycles -> in_ready drops after 2 accepted, and all 8 core_res values are delivered in order, unchanged, out_special=0.
REQ-025 The bench SHALL cover clr_flags asserted in the same cycle as a delivered inf result -> flag_invalid=1 and spec_cnt=1 afterwards; clr_flags alone -> all flags 0 and spec_cnt=0.
REQ-026 The bench SHALL cover rst asserted with 2 items in flight -> out_valid=0 and flags 0 after the edge, with no stale output afterwards; and CNT_W=2 with 5 special results -> spec_cnt=3.

Source files
------------

// File: rtl/fp_special_pipe.sv
`timescale 1ns/1ps
// fp_special_pipe: two-stage special-case override for a sin/cos datapath.
// Classifies the original IEEE754 operand (zero/subnormal/inf/nan) and
// either passes the core result through or substitutes the special-case
// result (QNAN, signed zero, or +1.0). It also keeps sticky special-event
// flags and a saturating count of delivered special results.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand + core-result pair handshake
//   func             0 = sin, 1 = cos
//   in_op, core_res  original operand, datapath result (W bits each)
//   out_valid/ready  result handshake
//   out_res          final result, out_special = came from special logic
//   clr_flags        clears sticky flags and spec_cnt (a set wins)
//   flag_invalid/nan/daz, spec_cnt   sticky status
module fp_special_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned DAZ   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   func,
  input  logic [EXP_W+MAN_W:0]   in_op,
  input  logic [EXP_W+MAN_W:0]   core_res,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic                   out_special,
  input  logic                   clr_flags,
  output logic                   flag_invalid,
  output logic                   flag_nan,
  output logic                   flag_daz,
  output logic [CNT_W-1:0]       spec_cnt
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  // Quiet NaN: positive sign, all-ones exponent and mantissa.
  localparam logic [W-1:0] QNAN    = {1'b0, {(W-1){1'b1}}};
  // +1.0: exponent equal to the bias, mantissa zero.
  localparam logic [W-1:0] ONE_VAL = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};

  // Operand classification (combinational, captured into S1)
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic             cls_zero, cls_flush, cls_inf, cls_nan;

  always_comb begin
    in_exp    = in_op[W-2 -: EXP_W];
    in_man    = in_op[MAN_W-1:0];
    cls_zero  = (~|in_exp) & (~|in_man);
    // Subnormals only take the zero path when flushing is enabled.
    cls_flush = (~|in_exp) & (|in_man) & (DAZ != 0);
    cls_inf   = (&in_exp) & (~|in_man);
    cls_nan   = (&in_exp) & (|in_man);
  end

  // Stage S1 registers
  logic           s1_valid_q, s1_valid_d;
  logic           s1_sign_q,  s1_sign_d;
  logic           s1_func_q,  s1_func_d;
  logic [W-1:0]   s1_core_q,  s1_core_d;
  logic           s1_zero_q,  s1_zero_d;
  logic           s1_flush_q, s1_flush_d;
  logic           s1_inf_q,   s1_inf_d;
  logic           s1_nan_q,   s1_nan_d;

  // Stage S2 registers (drive the outputs directly)
  logic           out_valid_q,   out_valid_d;
  logic [W-1:0]   out_res_q,     out_res_d;
  logic           out_special_q, out_special_d;
  logic           s2_inf_q,      s2_inf_d;
  logic           s2_nan_q,      s2_nan_d;
  logic           s2_flush_q,    s2_flush_d;

  // Sticky status
  logic             flag_invalid_q, flag_invalid_d;
  logic             flag_nan_q,     flag_nan_d;
  logic             flag_daz_q,     flag_daz_d;
  logic [CNT_W-1:0] spec_cnt_q,     spec_cnt_d;

  logic           s2_load;
  logic           accept;
  logic           out_hs;
  logic [W-1:0]   sel_res;
  logic           sel_special;

  // Special-case result selection from S1 contents
  always_comb begin
    sel_res     = s1_core_q;
    sel_special = 1'b0;
    if (s1_nan_q | s1_inf_q) begin
      sel_res     = QNAN;
      sel_special = 1'b1;
    end else if (s1_zero_q | s1_flush_q) begin
      sel_res     = s1_func_q ? ONE_VAL : {s1_sign_q, {(W-1){1'b0}}};
      sel_special = 1'b1;
    end
  end

  // Handshake / stage-advance control
  always_comb begin
    s2_load  = ~out_valid_q | out_ready;
    in_ready = ~s1_valid_q | s2_load;
    accept   = in_valid & in_ready;
    out_hs   = out_valid_q & out_ready;
  end

  // Next-state for pipeline and status
  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_sign_d      = s1_sign_q;
    s1_func_d      = s1_func_q;
    s1_core_d      = s1_core_q;
    s1_zero_d      = s1_zero_q;
    s1_flush_d     = s1_flush_q;
    s1_inf_d       = s1_inf_q;
    s1_nan_d       = s1_nan_q;
    out_valid_d    = out_valid_q;
    out_res_d      = out_res_q;
    out_special_d  = out_special_q;
    s2_inf_d       = s2_inf_q;
    s2_nan_d       = s2_nan_q;
    s2_flush_d     = s2_flush_q;
    flag_invalid_d = flag_invalid_q;
    flag_nan_d     = flag_nan_q;
    flag_daz_d     = flag_daz_q;
    spec_cnt_d     = spec_cnt_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_sign_d  = in_op[W-1];
      s1_func_d  = func;
      s1_core_d  = core_res;
      s1_zero_d  = cls_zero;
      s1_flush_d = cls_flush;
      s1_inf_d   = cls_inf;
      s1_nan_d   = cls_nan;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d     = sel_res;
        out_special_d = sel_special;
        s2_inf_d      = s1_inf_q;
        s2_nan_d      = s1_nan_q;
        s2_flush_d    = s1_flush_q;
      end
    end

    // Clear first, so a coincident set from the delivered item wins.
    if (clr_flags) begin
      flag_invalid_d = 1'b0;
      flag_nan_d     = 1'b0;
      flag_daz_d     = 1'b0;
      spec_cnt_d     = '0;
    end
    if (out_hs) begin
      if (s2_inf_q)   flag_invalid_d = 1'b1;
      if (s2_nan_q)   flag_nan_d     = 1'b1;
      if (s2_flush_q) flag_daz_d     = 1'b1;
      if (out_special_q) begin
        if (clr_flags)        spec_cnt_d = CNT_W'(1);
        else if (~&spec_cnt_q) spec_cnt_d = spec_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_sign_q      <= 1'b0;
      s1_func_q      <= 1'b0;
      s1_core_q      <= '0;
      s1_zero_q      <= 1'b0;
      s1_flush_q     <= 1'b0;
      s1_inf_q       <= 1'b0;
      s1_nan_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_res_q      <= '0;
      out_special_q  <= 1'b0;
      s2_inf_q       <= 1'b0;
      s2_nan_q       <= 1'b0;
      s2_flush_q     <= 1'b0;
      flag_invalid_q <= 1'b0;
      flag_nan_q     <= 1'b0;
      flag_daz_q     <= 1'b0;
      spec_cnt_q     <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_sign_q      <= s1_sign_d;
      s1_func_q      <= s1_func_d;
      s1_core_q      <= s1_core_d;
      s1_zero_q      <= s1_zero_d;
      s1_flush_q     <= s1_flush_d;
      s1_inf_q       <= s1_inf_d;
      s1_nan_q       <= s1_nan_d;
      out_valid_q    <= out_valid_d;
      out_res_q      <= out_res_d;
      out_special_q  <= out_special_d;
      s2_inf_q       <= s2_inf_d;
      s2_nan_q       <= s2_nan_d;
      s2_flush_q     <= s2_flush_d;
      flag_invalid_q <= flag_invalid_d;
      flag_nan_q     <= flag_nan_d;
      flag_daz_q     <= flag_daz_d;
      spec_cnt_q     <= spec_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_res      = out_res_q;
  assign out_special  = out_special_q;
  assign flag_invalid = flag_invalid_q;
  assign flag_nan     = flag_nan_q;
  assign flag_daz     = flag_daz_q;
  assign spec_cnt     = spec_cnt_q;

endmodule

// File: tb/tb_fp_special_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for fp_special_pipe. Three instances share stimulus:
// default parameters, CNT_W=2 (saturation), and DAZ=0 (subnormal pass-through).
module tb_fp_special_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        func = 1'b0;
  logic [31:0] in_op = '0;
  logic [31:0] core_res = '0;
  logic        out_ready = 1'b1;
  logic        clr_flags = 1'b0;

  logic        in_ready, out_valid, out_special, flag_invalid, flag_nan, flag_daz;
  logic [31:0] out_res;
  logic [15:0] spec_cnt;

  logic        c2_in_ready, c2_out_valid, c2_out_special, c2_inv, c2_nan, c2_daz;
  logic [31:0] c2_out_res;
  logic [1:0]  c2_cnt;

  logic        d0_in_ready, d0_out_valid, d0_out_special, d0_inv, d0_nan, d0_daz;
  logic [31:0] d0_out_res;
  logic [15:0] d0_cnt;

  always #5 clk = ~clk;

  fp_special_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .func(func),
    .in_op(in_op), .core_res(core_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_special(out_special), .clr_flags(clr_flags),
    .flag_invalid(flag_invalid), .flag_nan(flag_nan), .flag_daz(flag_daz), .spec_cnt(spec_cnt));

  fp_special_pipe #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready), .func(func),
    .in_op(in_op), .core_res(core_res), .out_valid(c2_out_valid), .out_ready(out_ready),
    .out_res(c2_out_res), .out_special(c2_out_special), .clr_flags(clr_flags),
    .flag_invalid(c2_inv), .flag_nan(c2_nan), .flag_daz(c2_daz), .spec_cnt(c2_cnt));

  fp_special_pipe #(.DAZ(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready), .func(func),
    .in_op(in_op), .core_res(core_res), .out_valid(d0_out_valid), .out_ready(out_ready),
    .out_res(d0_out_res), .out_special(d0_out_special), .clr_flags(clr_flags),
    .flag_invalid(d0_inv), .flag_nan(d0_nan), .flag_daz(d0_daz), .spec_cnt(d0_cnt));

  typedef struct {
    logic [31:0] res;   // expected with DAZ=1
    bit          sp;
    logic [31:0] res0;  // expected with DAZ=0
    bit          sp0;
    bit          inf;
    bit          nan;
    bit          sub;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;

  // Reference status state (reflects DUT state after the latest edge)
  bit   m_inv, m_nan, m_daz;
  int   m_cnt, m_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: classify the operand by its IEEE fields.
  function automatic exp_t ref_model(input bit f, input logic [31:0] op, input logic [31:0] core);
    exp_t        e;
    int          ex;
    int          ma;
    logic [31:0] zres;
    ex   = int'(op[30:23]);
    ma   = int'(op[22:0]);
    zres = f ? 32'h3F800000 : {op[31], 31'h0};
    e.inf = (ex == 255) && (ma == 0);
    e.nan = (ex == 255) && (ma != 0);
    e.sub = (ex == 0) && (ma != 0);
    if (ex == 255) begin
      e.res = 32'h7FFFFFFF; e.sp = 1; e.res0 = 32'h7FFFFFFF; e.sp0 = 1;
    end else if (ex == 0 && ma == 0) begin
      e.res = zres; e.sp = 1; e.res0 = zres; e.sp0 = 1;
    end else if (ex == 0) begin
      e.res = zres; e.sp = 1; e.res0 = core; e.sp0 = 0;
    end else begin
      e.res = core; e.sp = 0; e.res0 = core; e.sp0 = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_op();
    int          k;
    logic        s;
    logic [22:0] m;
    logic [7:0]  ex;
    k  = $urandom_range(0, 7);
    s  = 1'($urandom_range(0, 1));
    m  = 23'($urandom);
    if (m == 0) m = 23'd1;
    ex = 8'($urandom_range(1, 254));
    case (k)
      0:       return {s, 31'h0};
      1:       return {s, 8'h00, m};
      2:       return {s, 8'hFF, 23'h0};
      3:       return {s, 8'hFF, m};
      default: return {s, ex, m};
    endcase
  endfunction

  // Monitor / scoreboard: compares at the falling edge, then advances the model.
  logic        hold_v;
  logic [31:0] hold_res;
  logic        hold_sp;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb_q.delete();
      m_inv = 0; m_nan = 0; m_daz = 0; m_cnt = 0; m_cnt2 = 0;
      hold_v = 1'b0;
    end else begin
      check("flag_invalid", 32'(flag_invalid), 32'(m_inv));
      check("flag_nan", 32'(flag_nan), 32'(m_nan));
      check("flag_daz", 32'(flag_daz), 32'(m_daz));
      check("spec_cnt", 32'(spec_cnt), 32'(m_cnt));
      check("spec_cnt_w2", 32'(c2_cnt), 32'(m_cnt2));
      check("out_valid_d0", 32'(d0_out_valid), 32'(out_valid));
      if (hold_v) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_res", out_res, hold_res);
        check("stall_special", 32'(out_special), 32'(hold_sp));
      end
      hold_v   = out_valid && !out_ready;
      hold_res = out_res;
      hold_sp  = out_special;

      if (clr_flags) begin
        m_inv = 0; m_nan = 0; m_daz = 0; m_cnt = 0; m_cnt2 = 0;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL stale_output: got %h expected no output at %0t", out_res, $time);
        end else begin
          e = sb_q.pop_front();
          check("out_res", out_res, e.res);
          check("out_special", 32'(out_special), 32'(e.sp));
          check("out_res_w2", c2_out_res, e.res);
          check("out_res_daz0", d0_out_res, e.res0);
          check("out_special_daz0", 32'(d0_out_special), 32'(e.sp0));
          if (e.inf) m_inv = 1;
          if (e.nan) m_nan = 1;
          if (e.sub) m_daz = 1;
          if (e.sp) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(ref_model(func, in_op, core_res));
        acc_cnt++;
      end
    end
  end

  // Present one pair, hold until accepted (bounded), return at posedge+1.
  task automatic send(input bit f, input logic [31:0] op, input logic [31:0] core);
    bit ok;
    ok = 0;
    func = f; in_op = op; core_res = core; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic wait_out_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  acc0;
    bit  done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'd0);
    check("rst_out_special", 32'(out_special), 32'd0);
    check("rst_spec_cnt", 32'(spec_cnt), 32'd0);
    @(posedge clk); #1;

    // sin(-0): latency and result
    in_valid = 1'b1; func = 1'b0; in_op = 32'h80000000; core_res = 32'h12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(out_valid), 32'd1);
    check("sin_negzero_res", out_res, 32'h80000000);
    check("sin_negzero_special", 32'(out_special), 32'd1);
    @(posedge clk); #1;
    check("sin_negzero_cnt", 32'(spec_cnt), 32'd1);

    // cos(0), cos(subnormal), inf, nan
    send(1'b1, 32'h00000000, $urandom);
    send(1'b1, 32'h00000001, 32'hCAFEF00D);
    send(1'b0, 32'hFF800000, $urandom);
    send(1'b1, 32'h7FC00001, $urandom);
    drain();
    check("dir_flag_daz", 32'(flag_daz), 32'd1);
    check("dir_flag_invalid", 32'(flag_invalid), 32'd1);
    check("dir_flag_nan", 32'(flag_nan), 32'd1);
    check("dir_spec_cnt", 32'(spec_cnt), 32'd5);

    // 8 normal operands with the output stalled for 5 cycles
    acc0 = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(1'b0, 32'h3F000000, $urandom);
      end
    join_none
    repeat (5) @(posedge clk);
    #2;
    check("stall_accepted", 32'(acc_cnt - acc0), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait fork;
    drain();
    check("stream_accepted", 32'(acc_cnt - acc0), 32'd8);

    // clr alone, then clr coinciding with a delivered inf
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("clr_flag_invalid", 32'(flag_invalid), 32'd0);
    check("clr_flag_nan", 32'(flag_nan), 32'd0);
    check("clr_flag_daz", 32'(flag_daz), 32'd0);
    check("clr_spec_cnt", 32'(spec_cnt), 32'd0);
    out_ready = 1'b0;
    send(1'b0, 32'hFF800000, $urandom);
    wait_out_valid();
    clr_flags = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("clrset_flag_invalid", 32'(flag_invalid), 32'd1);
    check("clrset_spec_cnt", 32'(spec_cnt), 32'd1);
    drain();

    // Randomized traffic with random backpressure and occasional clears
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(1'($urandom_range(0, 1)), rnd_op(), $urandom);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          clr_flags = ($urandom_range(0, 31) == 0);
        end
        out_ready = 1'b1;
        clr_flags = 1'b0;
      end
    join
    drain();

    // Reset with two items in flight
    send(1'b0, 32'h7F800000, $urandom);
    send(1'b0, 32'h7FC00000, $urandom);
    send(1'b0, 32'h00000005, $urandom);
    drain();
    out_ready = 1'b0;
    send(1'b0, 32'h3F000000, $urandom);
    send(1'b1, 32'h40000000, $urandom);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_flag_invalid", 32'(flag_invalid), 32'd0);
    check("midrst_flag_nan", 32'(flag_nan), 32'd0);
    check("midrst_flag_daz", 32'(flag_daz), 32'd0);
    check("midrst_spec_cnt", 32'(spec_cnt), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Counter saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) send(1'b0, 32'h00000000, $urandom);
    drain();
    check("sat_cnt_w2", 32'(c2_cnt), 32'd3);
    check("sat_cnt_w16", 32'(spec_cnt), 32'd5);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
